// File: rtl/cnn_seq_pkg.sv
// rtl/cnn_seq_pkg.sv - shared types and constants for the CNN layer sequencer
//
// Contents:
//   seq_state_t      sequencer FSM state encoding
//   stage_idx_w(n)   width of a stage index, max(1, $clog2(n))
//   DEF_WDOG_CYCLES  default per-stage watchdog limit in cycles
package cnn_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } seq_state_t;

    localparam int DEF_WDOG_CYCLES = 1 << 20;

    function automatic int stage_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - per-stage hang detector for the layer sequencer
//
// Ports:
//   clk1     in   sole clock
//   rst_n    in   synchronous reset, active high
//   clr      in   restart the count (stage being launched)
//   en       in   count this cycle (stage running)
//   expired  out  this is the LIMIT-th counted cycle without a restart
import cnn_seq_pkg::*;

module seq_watchdog #(
    parameter int LIMIT = DEF_WDOG_CYCLES
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of enabled cycles already elapsed, so the
    // current enabled cycle is number cnt+1; expiry fires on the LIMIT-th.
    always_ff @(posedge clk1) begin
        if (rst_n || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - strict-order run controller for the CNN stage pipeline
//
// Optional feature: define SEQ_WATCHDOG_EN to add the per-stage watchdog and
// the ERROR state; without it err is tied to 0 and WAIT is unbounded.
//
// Ports:
//   clk1         in   sole clock
//   rst_n        in   synchronous reset, active high (name kept from the codebase)
//   start        in   run request, sampled only in IDLE (and ERROR)
//   stage_skip   in   bypass mask, captured on the accepted start
//   stage_done   in   per-stage end pulses; only the active index is honoured
//   stage_start  out  one-cycle launch pulse, one-hot or zero
//   stage_en     out  registered clock-enable, one-hot or zero
//   cur_stage    out  active stage index in LAUNCH/WAIT (held in ERROR), else 0
//   busy         out  run in progress
//   end_op       out  one-cycle pulse on run completion
//   err          out  sticky watchdog flag
import cnn_seq_pkg::*;

module layer_sequencer #(
    parameter int NUM_STAGES  = 8,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                                clk1,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [NUM_STAGES-1:0]               stage_skip,
    input  logic [NUM_STAGES-1:0]               stage_done,
    output logic [NUM_STAGES-1:0]               stage_start,
    output logic [NUM_STAGES-1:0]               stage_en,
    output logic [stage_idx_w(NUM_STAGES)-1:0]  cur_stage,
    output logic                                busy,
    output logic                                end_op,
    output logic                                err
);

    localparam int IDX_W = stage_idx_w(NUM_STAGES);

    if (NUM_STAGES < 1 || WDOG_CYCLES < 1) begin : g_param_check
        $error("layer_sequencer: NUM_STAGES and WDOG_CYCLES must be at least 1");
    end

    seq_state_t            state, next_state;
    logic [IDX_W-1:0]      idx, next_idx;
    logic [NUM_STAGES-1:0] skip_q, next_skip;

    logic [NUM_STAGES-1:0] start_d, en_d;
    logic [IDX_W-1:0]      cur_d;
    logic                  busy_d, end_d;

    logic last_stage;
    assign last_stage = (idx == IDX_W'(NUM_STAGES - 1));

`ifdef SEQ_WATCHDOG_EN
    logic wd_expired;
    logic err_d;

    seq_watchdog #(
        .LIMIT(WDOG_CYCLES)
    ) u_watchdog (
        .clk1   (clk1),
        .rst_n  (rst_n),
        .clr    (state == LAUNCH),
        .en     (state == WAIT),
        .expired(wd_expired)
    );
`endif

    // State register. Outputs are registered too: they are decoded from the
    // next state, so each output flop shows exactly what the state implies in
    // the following cycle and stage_en reaches the clock gates glitch-free.
    always_ff @(posedge clk1) begin
        if (rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            skip_q      <= '0;
            stage_start <= '0;
            stage_en    <= '0;
            cur_stage   <= '0;
            busy        <= 1'b0;
            end_op      <= 1'b0;
        end else begin
            state       <= next_state;
            idx         <= next_idx;
            skip_q      <= next_skip;
            stage_start <= start_d;
            stage_en    <= en_d;
            cur_stage   <= cur_d;
            busy        <= busy_d;
            end_op      <= end_d;
        end
    end

    // Next-state logic. A done pulse seen in LAUNCH advances straight away,
    // so a stage can occupy a single cycle and stages run back to back.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        next_skip  = skip_q;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LAUNCH;
                    next_idx   = '0;
                    next_skip  = stage_skip;
                end
            end
            LAUNCH, WAIT: begin
                if ((state == LAUNCH && skip_q[idx]) || stage_done[idx]) begin
                    if (last_stage) begin
                        next_state = DONE;
                    end else begin
                        next_state = LAUNCH;
                        next_idx   = idx + 1'b1;
                    end
                end else if (state == LAUNCH) begin
                    next_state = WAIT;
`ifdef SEQ_WATCHDOG_EN
                end else if (wd_expired) begin
                    next_state = ERROR;
`endif
                end
            end
            DONE: begin
                next_state = IDLE;
                next_idx   = '0;
            end
`ifdef SEQ_WATCHDOG_EN
            ERROR: begin
                // idx is held so cur_stage keeps pointing at the hung stage
                if (start) begin
                    next_state = LAUNCH;
                    next_idx   = '0;
                    next_skip  = stage_skip;
                end
            end
`endif
            default: begin
                next_state = IDLE;
                next_idx   = '0;
            end
        endcase
    end

    // Output decode from the next state, index and skip mask.
    always_comb begin
        start_d = '0;
        en_d    = '0;
        cur_d   = '0;
        busy_d  = 1'b0;
        end_d   = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        err_d   = 1'b0;
`endif
        case (next_state)
            LAUNCH: begin
                busy_d = 1'b1;
                cur_d  = next_idx;
                if (!next_skip[next_idx]) begin
                    start_d[next_idx] = 1'b1;
                    en_d[next_idx]    = 1'b1;
                end
            end
            WAIT: begin
                busy_d         = 1'b1;
                cur_d          = next_idx;
                en_d[next_idx] = 1'b1;
            end
            DONE: begin
                end_d = 1'b1;
            end
`ifdef SEQ_WATCHDOG_EN
            ERROR: begin
                cur_d = next_idx;
                err_d = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

`ifdef SEQ_WATCHDOG_EN
    logic err_q;

    always_ff @(posedge clk1) begin
        if (rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - directed self-checking bench for layer_sequencer
module tb_layer_sequencer;

    logic       clk1 = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] stage_skip;
    logic [3:0] stage_done;
    logic [3:0] stage_start;
    logic [3:0] stage_en;
    logic [1:0] cur_stage;
    logic       busy;
    logic       end_op;
    logic       err;

    int passed = 0;
    int total  = 0;

    // {stage_start, stage_en, cur_stage, busy, end_op, err}
    logic [12:0] obs;
    assign obs = {stage_start, stage_en, cur_stage, busy, end_op, err};

    layer_sequencer #(
        .NUM_STAGES (4),
        .WDOG_CYCLES(16)
    ) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .start      (start),
        .stage_skip (stage_skip),
        .stage_done (stage_done),
        .stage_start(stage_start),
        .stage_en   (stage_en),
        .cur_stage  (cur_stage),
        .busy       (busy),
        .end_op     (end_op),
        .err        (err)
    );

    always #5 clk1 = ~clk1;

    // Every test runs on the falling edge: check the outputs of the current
    // cycle, then drive the inputs that the next rising edge samples.

    task automatic test_reset;
        rst_n      = 1'b1;
        start      = 1'b1;
        stage_done = 4'b1111;
        stage_skip = 4'b0000;
        @(negedge clk1);
        @(negedge clk1);
        total++;
        if (obs !== 13'b0) $display("FAIL reset_hold got %b want %b", obs, 13'b0);
        else passed++;
        rst_n      = 1'b0;
        start      = 1'b0;
        stage_done = 4'b0000;
        @(negedge clk1);
        total++;
        if (obs !== 13'b0) $display("FAIL reset_idle got %b want %b", obs, 13'b0);
        else passed++;
    endtask

    // 4 stages, each done 5 cycles after its launch pulse:
    // launches at t=1,7,13,19, end_op at t=25.
    task automatic test_normal_run;
        logic [3:0] es, ee;
        logic [1:0] ec;
        logic       eb, eo;
        int         k;
        stage_skip = 4'b0000;
        for (int t = 0; t <= 26; t++) begin
            es = '0; ee = '0; ec = '0; eb = 1'b0; eo = 1'b0;
            if (t >= 1 && t <= 24) begin
                k      = (t - 1) / 6;
                ee[k]  = 1'b1;
                ec     = 2'(k);
                eb     = 1'b1;
                if ((t - 1) % 6 == 0) es[k] = 1'b1;
            end
            if (t == 25) eo = 1'b1;
            total++;
            if (obs !== {es, ee, ec, eb, eo, 1'b0})
                $display("FAIL normal_run t=%0d got %b want %b", t, obs, {es, ee, ec, eb, eo, 1'b0});
            else passed++;
            start      = (t == 0);
            stage_done = '0;
            if (t >= 6 && t <= 24 && t % 6 == 0) stage_done[t/6 - 1] = 1'b1;
            @(negedge clk1);
        end
        start      = 1'b0;
        stage_done = '0;
    endtask

    // Mask 0101: stages 0 and 2 bypassed (1 cycle each); mask changes after
    // the accepted start must not matter.
    task automatic test_skip_mask;
        logic [12:0] ex [10] = '{
            13'b0000_0000_00_000,
            13'b0000_0000_00_100,
            13'b0010_0010_01_100,
            13'b0000_0010_01_100,
            13'b0000_0010_01_100,
            13'b0000_0000_10_100,
            13'b1000_1000_11_100,
            13'b0000_1000_11_100,
            13'b0000_0000_00_010,
            13'b0000_0000_00_000};
        logic [5:0] dr [10] = '{
            6'b01_0000, 6'b00_0000, 6'b00_0000, 6'b00_0000, 6'b00_0010,
            6'b00_0000, 6'b00_0000, 6'b00_1000, 6'b00_0000, 6'b00_0000};
        stage_skip = 4'b0101;
        for (int t = 0; t < 10; t++) begin
            total++;
            if (obs !== ex[t]) $display("FAIL skip_mask t=%0d got %b want %b", t, obs, ex[t]);
            else passed++;
            {rst_n, start, stage_done} = dr[t];
            if (t == 1) stage_skip = 4'b1010;
            @(negedge clk1);
        end
        {rst_n, start, stage_done} = '0;
        stage_skip = 4'b0000;
    endtask

    // Done during LAUNCH advances immediately; done on a wrong index during
    // WAIT does not; start during a run and during DONE is ignored.
    task automatic test_launch_done_wrong_idx;
        logic [12:0] ex [11] = '{
            13'b0000_0000_00_000,
            13'b0001_0001_00_100,
            13'b0010_0010_01_100,
            13'b0000_0010_01_100,
            13'b0000_0010_01_100,
            13'b0000_0010_01_100,
            13'b0100_0100_10_100,
            13'b1000_1000_11_100,
            13'b0000_0000_00_010,
            13'b0000_0000_00_000,
            13'b0000_0000_00_000};
        logic [5:0] dr [11] = '{
            6'b01_0000, 6'b00_0001, 6'b00_0000, 6'b01_0100, 6'b00_1101,
            6'b00_0010, 6'b00_0100, 6'b00_1000, 6'b01_0000, 6'b00_0000,
            6'b00_0000};
        stage_skip = 4'b0000;
        for (int t = 0; t < 11; t++) begin
            total++;
            if (obs !== ex[t]) $display("FAIL launch_wrong_idx t=%0d got %b want %b", t, obs, ex[t]);
            else passed++;
            {rst_n, start, stage_done} = dr[t];
            @(negedge clk1);
        end
        {rst_n, start, stage_done} = '0;
    endtask

    // All stages skipped: end_op NUM_STAGES+1 = 5 cycles after the start edge.
    task automatic test_all_skipped;
        logic [12:0] ex [7] = '{
            13'b0000_0000_00_000,
            13'b0000_0000_00_100,
            13'b0000_0000_01_100,
            13'b0000_0000_10_100,
            13'b0000_0000_11_100,
            13'b0000_0000_00_010,
            13'b0000_0000_00_000};
        stage_skip = 4'b1111;
        for (int t = 0; t < 7; t++) begin
            total++;
            if (obs !== ex[t]) $display("FAIL all_skipped t=%0d got %b want %b", t, obs, ex[t]);
            else passed++;
            start = (t == 0);
            @(negedge clk1);
        end
        start      = 1'b0;
        stage_skip = 4'b0000;
    endtask

    // Reset while stage 2 waits (with start and done also high), then a
    // fresh start relaunches from stage 0 with back-to-back stages.
    task automatic test_reset_mid_run;
        logic [12:0] ex [11] = '{
            13'b0000_0000_00_000,
            13'b0001_0001_00_100,
            13'b0010_0010_01_100,
            13'b0100_0100_10_100,
            13'b0000_0100_10_100,
            13'b0000_0000_00_000,
            13'b0001_0001_00_100,
            13'b0010_0010_01_100,
            13'b0100_0100_10_100,
            13'b1000_1000_11_100,
            13'b0000_0000_00_010};
        logic [5:0] dr [11] = '{
            6'b01_0000, 6'b00_0001, 6'b00_0010, 6'b00_0000, 6'b11_0100,
            6'b01_0000, 6'b00_0001, 6'b00_0010, 6'b00_0100, 6'b00_1000,
            6'b00_0000};
        stage_skip = 4'b0000;
        for (int t = 0; t < 11; t++) begin
            total++;
            if (obs !== ex[t]) $display("FAIL reset_mid_run t=%0d got %b want %b", t, obs, ex[t]);
            else passed++;
            {rst_n, start, stage_done} = dr[t];
            @(negedge clk1);
        end
        {rst_n, start, stage_done} = '0;
        @(negedge clk1);
    endtask

`ifdef SEQ_WATCHDOG_EN
    // Stage 1 launched at t=2 and never done: ERROR at t=19 (17 cycles later).
    task automatic test_watchdog_expire;
        stage_skip = 4'b0000;
        start      = 1'b1;
        @(negedge clk1);
        start      = 1'b0;
        stage_done = 4'b0001;
        @(negedge clk1);
        stage_done = 4'b0000;
        total++;
        if (obs !== 13'b0010_0010_01_100) $display("FAIL wdog_launch got %b want %b", obs, 13'b0010_0010_01_100);
        else passed++;
        for (int t = 3; t <= 18; t++) begin
            @(negedge clk1);
            total++;
            if (obs !== 13'b0000_0010_01_100) $display("FAIL wdog_wait t=%0d got %b want %b", t, obs, 13'b0000_0010_01_100);
            else passed++;
        end
        @(negedge clk1);
        total++;
        if (obs !== 13'b0000_0000_01_001) $display("FAIL wdog_error got %b want %b", obs, 13'b0000_0000_01_001);
        else passed++;
        @(negedge clk1);
        total++;
        if (obs !== 13'b0000_0000_01_001) $display("FAIL wdog_sticky got %b want %b", obs, 13'b0000_0000_01_001);
        else passed++;
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        total++;
        if (obs !== 13'b0001_0001_00_100) $display("FAIL wdog_restart got %b want %b", obs, 13'b0001_0001_00_100);
        else passed++;
        stage_done = 4'b0001; @(negedge clk1);
        stage_done = 4'b0010; @(negedge clk1);
        stage_done = 4'b0100; @(negedge clk1);
        stage_done = 4'b1000; @(negedge clk1);
        stage_done = 4'b0000;
        total++;
        if (obs !== 13'b0000_0000_00_010) $display("FAIL wdog_rerun_end got %b want %b", obs, 13'b0000_0000_00_010);
        else passed++;
        @(negedge clk1);
    endtask

    // Done arrives in the expiry cycle: normal advance, no error.
    task automatic test_watchdog_done_at_expiry;
        stage_skip = 4'b0000;
        start      = 1'b1;
        @(negedge clk1);
        start      = 1'b0;
        stage_done = 4'b0001;
        @(negedge clk1);
        stage_done = 4'b0000;
        for (int t = 3; t <= 18; t++) begin
            @(negedge clk1);
            if (t == 18) stage_done = 4'b0010;
        end
        @(negedge clk1);
        stage_done = 4'b0000;
        total++;
        if (obs !== 13'b0100_0100_10_100) $display("FAIL wdog_expiry_done got %b want %b", obs, 13'b0100_0100_10_100);
        else passed++;
        stage_done = 4'b0100; @(negedge clk1);
        stage_done = 4'b1000; @(negedge clk1);
        stage_done = 4'b0000;
        total++;
        if (obs !== 13'b0000_0000_00_010) $display("FAIL wdog_expiry_end got %b want %b", obs, 13'b0000_0000_00_010);
        else passed++;
        @(negedge clk1);
    endtask
`endif

    initial begin
        rst_n      = 1'b1;
        start      = 1'b0;
        stage_skip = 4'b0000;
        stage_done = 4'b0000;
        @(negedge clk1);
        test_reset();
        test_normal_run();
        test_skip_mask();
        test_launch_done_wrong_idx();
        test_all_skipped();
        test_reset_mid_run();
`ifdef SEQ_WATCHDOG_EN
        test_watchdog_expire();
        test_watchdog_done_at_expiry();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Central run controller for the CNN accelerator pipeline. On a single `start` it launches each compute stage (CONV/POOL/FC/SOFTMAX groups) in strict order, holds that stage's registered clock-enable high only while it runs, waits for its end pulse, and raises `end_op` after the last stage. It replaces the per-layer combinational start/end latches with one synchronous FSM. An optional watchdog flags a hung stage.

## Interface
- `NUM_STAGES`, default 8: number of sequenced stages; minimum 1.
- `WDOG_CYCLES`, default 2^20: watchdog limit per stage, in cycles; used only with `SEQ_WATCHDOG_EN`.
- `clk1`  in  1  sole clock.
- `rst_n`  in  1  synchronous, active-high reset (1 = reset); the name is kept for codebase consistency.
- `start`  in  1  run request; sampled only in IDLE.
- `stage_skip`  in  NUM_STAGES  bypass mask; captured on the accepted `start`.
- `stage_done`  in  NUM_STAGES  per-stage end pulses (end_conv/end_pool/...).
- `stage_start`  out  NUM_STAGES  one-cycle launch pulse, one-hot or zero.
- `stage_en`  out  NUM_STAGES  registered clock-enable, one-hot or zero.
- `cur_stage`  out  $clog2(NUM_STAGES) (min 1)  index of the active stage.
- `busy`  out  1  high from the cycle after `start` is accepted until `end_op` or ERROR.
- `end_op`  out  1  one-cycle pulse when the run completes.
- `err`  out  1  sticky watchdog flag; constant 0 without the macro.

## Operation
- States: IDLE, LAUNCH, WAIT, DONE, ERROR.
- IDLE: when `start`=1, capture `stage_skip` into `skip_q`, set idx=0, clear `err`, and go to LAUNCH.
- LAUNCH, when `skip_q[idx]`=1: no pulse and no enable. If idx is the last stage, go to DONE; otherwise idx+1 and stay in LAUNCH. Each skipped stage costs 1 cycle.
- LAUNCH, when `skip_q[idx]`=0: drive `stage_start[idx]`=1 and `stage_en[idx]`=1 in this cycle, then go to WAIT.
- WAIT: hold `stage_en[idx]`. When `stage_done[idx]`=1, `stage_en` is cleared in the next cycle. Then go to DONE if idx is the last stage, else idx+1 and go to LAUNCH.
- A `stage_done[idx]` asserted during the LAUNCH cycle is honoured: the FSM skips WAIT and goes to NEXT handling directly.
- `stage_done` bits for any stage other than idx are ignored.
- DONE: `end_op`=1 for one cycle, `busy`=0, then go to IDLE.
- `start` while not in IDLE is ignored. It is not queued.
- `cur_stage` equals idx in LAUNCH and WAIT; 0 otherwise.
- ERROR (watchdog only): all enables are 0, `err`=1, `busy`=0. A new `start` restarts a run exactly as from IDLE.

## Timing
- Reset values: IDLE, idx=0; `stage_start`, `stage_en`, `cur_stage`, `busy`, `end_op`, `err` all 0.
- Reset asserted mid-run: all outputs are 0 on the next edge. Reset has priority over `start` and `stage_done` in the same cycle.
- `start` sampled at edge N: `stage_start[0]` and `stage_en[0]` are high in cycle N+1, and `busy` is high from N+1.
- `stage_done[i]` sampled in cycle T:
  - `stage_en[i]`=0 in cycle T+1;
  - `stage_start[i+1]` in cycle T+1 if not skipped;
  - otherwise `end_op` in cycle T+1 for the last stage.
- An active stage occupies at minimum one cycle (done during LAUNCH). Back-to-back stages therefore have no idle gap.
- All skipped: `end_op` is asserted NUM_STAGES+1 cycles after the `start` edge.
- `stage_en` is register-driven and glitch-free. It feeds the existing clock-gate cells.

## Configuration
- `SEQ_WATCHDOG_EN` defined:
  - a per-stage counter clears in LAUNCH and increments in WAIT;
  - when it reaches `WDOG_CYCLES` with no `stage_done[idx]`, the FSM enters ERROR the next cycle, `err`=1, and `cur_stage` freezes at the failing idx;
  - `stage_done` arriving in the same cycle as expiry takes priority (no error).
- `SEQ_WATCHDOG_EN` undefined: no counter and no ERROR state; `err` is tied to 0; WAIT is unbounded.

## Structure
- Shared package `cnn_seq_pkg`: state enum `seq_state_t`, function `stage_idx_w(n)` returning max(1,$clog2(n)), and default `WDOG_CYCLES` constant.
- Sub-module `seq_watchdog` (counter + expiry compare, clear/enable inputs), instantiated only under `SEQ_WATCHDOG_EN`.
- The FSM and the idx/skip registers live in `layer_sequencer`.

## Test plan
- NUM_STAGES=4, no skips, each `stage_done` 5 cycles after its `stage_start`: expect pulses at cycles 1, 7, 13, 19 after `start`, `end_op` at cycle 25, and `stage_en` one-hot throughout.
- `stage_skip`=4'b0101: expect only stages 1 and 3 to be launched, and `cur_stage` 1 then 3; skipped stages each add exactly 1 cycle.
- `stage_done[idx]` in the LAUNCH cycle, and `stage_done` on a wrong index during WAIT: expect immediate advance in the first case and no advance in the second.
- Reset asserted while stage 2 is in WAIT: all outputs are 0 next cycle; a subsequent `start` relaunches from stage 0. A second `start` during a run is ignored.
- Watchdog on, `WDOG_CYCLES`=16, stage 1 never done: `err`=1 and ERROR 17 cycles after `stage_start[1]`, `cur_stage`=1, enables 0. A new `start` clears `err` and runs normally.
- Watchdog on, `stage_done` exactly at expiry: no error and a normal advance.
